// File: rtl/common_pkg.sv
// Shared types for the warp pipeline: data word, warp phase and LSU state.
package common_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    WARP_IDLE,
    WARP_FETCH,
    WARP_DECODE,
    WARP_EXECUTE,
    WARP_REQUEST,
    WARP_UPDATE
  } warp_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_t;

endpackage

// File: rtl/warp_lsu_lane_pick.sv
// Lowest-set-bit encoder used by warp_lsu to choose the next lane to serve.
module lane_pick #(
  parameter int THREADS_PER_WARP = 4,
  localparam int TID_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1
) (
  input  logic [THREADS_PER_WARP-1:0] pending,
  output logic [TID_W-1:0]            idx,
  output logic                        any
);

  // Scanning downward leaves the lowest set bit as the final winner.
  always_comb begin
    idx = '0;
    for (int i = THREADS_PER_WARP - 1; i >= 0; i--) begin
      if (pending[i]) idx = TID_W'(i);
    end
  end

  assign any = |pending;

endmodule

// File: rtl/warp_lsu.sv
// Per-warp load/store unit serialising enabled lanes onto one memory port.
// Define LSU_COALESCE_EN to let one load response satisfy all same-address lanes.
import common_pkg::*;

module warp_lsu #(
  parameter int THREADS_PER_WARP = 4,
  parameter int ADDR_WIDTH       = 32,
  localparam int TID_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  warp_state_t                 warp_state,
  input  logic                        warp_enable,
  input  logic [THREADS_PER_WARP-1:0] thread_enable,
  input  logic                        DMemEN,
  input  logic                        DMemRW,
  input  data_t                       imm,
  input  data_t                       rs1 [THREADS_PER_WARP],
  input  data_t                       rs2 [THREADS_PER_WARP],
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output data_t                       mem_req_wdata,
  input  logic                        mem_rsp_valid,
  input  data_t                       mem_rsp_rdata,
  output data_t                       lsu_out [THREADS_PER_WARP],
  output logic                        lsu_done
);

  lsu_state_t                  state;
  logic [ADDR_WIDTH-1:0]       addr_q  [THREADS_PER_WARP];
  data_t                       wdata_q [THREADS_PER_WARP];
  logic                        we_q;
  logic [THREADS_PER_WARP-1:0] pending;
  logic [TID_W-1:0]            idx_q;
  logic [THREADS_PER_WARP-1:0] idx_mask;
  logic [THREADS_PER_WARP-1:0] done_mask;
  logic [THREADS_PER_WARP-1:0] pick_src;
  logic [TID_W-1:0]            nidx;
  logic                        nany;
  logic [ADDR_WIDTH-1:0]       next_addr;
  data_t                       next_wdata;
  logic                        start;

  assign start = warp_enable && (warp_state == WARP_REQUEST) && DMemEN;

  always_comb begin
    idx_mask        = '0;
    idx_mask[idx_q] = 1'b1;
  end

  // Lanes retired by a load response: the served lane, plus same-address lanes when coalescing.
  always_comb begin
    done_mask = idx_mask;
`ifdef LSU_COALESCE_EN
    for (int t = 0; t < THREADS_PER_WARP; t++) begin
      if (pending[t] && (addr_q[t] == addr_q[idx_q])) done_mask[t] = 1'b1;
    end
`else
    done_mask = idx_mask;
`endif
  end

  // Pick from the mask as it will look after this cycle so the next request is registered without a bubble.
  always_comb begin
    case (state)
      LSU_IDLE: pick_src = thread_enable;
      LSU_WAIT: pick_src = pending & ~done_mask;
      default:  pick_src = pending;
    endcase
  end

  lane_pick #(.THREADS_PER_WARP(THREADS_PER_WARP)) u_pick (
    .pending (pick_src),
    .idx     (nidx),
    .any     (nany)
  );

  always_comb begin
    if (state == LSU_IDLE) begin
      next_addr  = ADDR_WIDTH'(rs1[nidx] + imm);
      next_wdata = rs2[nidx];
    end else begin
      next_addr  = addr_q[nidx];
      next_wdata = wdata_q[nidx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= LSU_IDLE;
      pending       <= '0;
      we_q          <= 1'b0;
      idx_q         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      lsu_done      <= 1'b0;
      for (int t = 0; t < THREADS_PER_WARP; t++) begin
        lsu_out[t] <= '0;
        addr_q[t]  <= '0;
        wdata_q[t] <= '0;
      end
    end else begin
      case (state)
        LSU_IDLE: begin
          if (start) begin
            for (int t = 0; t < THREADS_PER_WARP; t++) begin
              addr_q[t]  <= ADDR_WIDTH'(rs1[t] + imm);
              wdata_q[t] <= rs2[t];
            end
            we_q    <= DMemRW;
            pending <= thread_enable;
            if (nany) begin
              state         <= LSU_ISSUE;
              mem_req_valid <= 1'b1;
              mem_req_we    <= DMemRW;
              mem_req_addr  <= next_addr;
              mem_req_wdata <= next_wdata;
              idx_q         <= nidx;
            end else begin
              state    <= LSU_DONE;
              lsu_done <= 1'b1;
            end
          end
        end
        LSU_ISSUE: begin
          if (!mem_req_valid) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= we_q;
            mem_req_addr  <= next_addr;
            mem_req_wdata <= next_wdata;
            idx_q         <= nidx;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (we_q) begin
              pending <= pending & ~idx_mask;
              if ((pending & ~idx_mask) == '0) begin
                state    <= LSU_DONE;
                lsu_done <= 1'b1;
              end
            end else begin
              state <= LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (mem_rsp_valid) begin
            for (int t = 0; t < THREADS_PER_WARP; t++) begin
              if (done_mask[t]) lsu_out[t] <= mem_rsp_rdata;
            end
            pending <= pending & ~done_mask;
            if (nany) begin
              state         <= LSU_ISSUE;
              mem_req_valid <= 1'b1;
              mem_req_we    <= we_q;
              mem_req_addr  <= next_addr;
              mem_req_wdata <= next_wdata;
              idx_q         <= nidx;
            end else begin
              state    <= LSU_DONE;
              lsu_done <= 1'b1;
            end
          end
        end
        LSU_DONE: begin
          if (warp_enable && (warp_state == WARP_UPDATE)) begin
            state    <= LSU_IDLE;
            lsu_done <= 1'b0;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_lsu.sv
// Scoreboard bench for warp_lsu: expected requests/results queued by stimulus, checked by a monitor.
module tb_warp_lsu;
  import common_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  typedef logic [3:0][31:0] lanes_t;

  logic        clk;
  logic        reset;
  warp_state_t warp_state;
  logic        warp_enable;
  logic [3:0]  thread_enable;
  logic        DMemEN;
  logic        DMemRW;
  data_t       imm;
  data_t       rs1 [4];
  data_t       rs2 [4];
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  data_t       mem_req_wdata;
  logic        mem_rsp_valid;
  data_t       mem_rsp_rdata;
  data_t       lsu_out [4];
  logic        lsu_done;

  int vectors     = 0;
  int miscompares = 0;

  req_t   exp_req[$];
  lanes_t exp_res[$];

  logic  rsp_model  = 1'b0;
  logic  late_rsp   = 1'b0;
  logic  rsp_enable = 1'b1;
  data_t rsp_data   = '0;
  data_t late_data  = '0;
  int    stall_cnt  = 0;
  int    cycles;

  assign mem_rsp_valid = rsp_model | late_rsp;
  assign mem_rsp_rdata = late_rsp ? late_data : rsp_data;

  warp_lsu #(.THREADS_PER_WARP(4), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .warp_state    (warp_state),
    .warp_enable   (warp_enable),
    .thread_enable (thread_enable),
    .DMemEN        (DMemEN),
    .DMemRW        (DMemRW),
    .imm           (imm),
    .rs1           (rs1),
    .rs2           (rs2),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .lsu_out       (lsu_out),
    .lsu_done      (lsu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushReq(input logic [31:0] a, input logic w, input logic [31:0] d);
    req_t r;
    r.addr  = a;
    r.we    = w;
    r.wdata = d;
    exp_req.push_back(r);
  endtask

  // Memory model: 1-cycle response to accepted loads with data = addr*2; optional ready stall.
  initial begin
    logic        hs;
    logic [31:0] a;
    mem_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs = (reset === 1'b1) && mem_req_valid && mem_req_ready && !mem_req_we;
      a  = mem_req_addr;
      @(posedge clk);
      #1;
      rsp_model = hs && rsp_enable;
      rsp_data  = a << 1;
      if (stall_cnt > 0) begin
        mem_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  // Monitor: compares each presented request and each completed warp against the queues.
  initial begin
    logic   done_prev;
    lanes_t r;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (mem_req_valid) begin
          if (exp_req.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_req: got addr 0x%0h, expected no request", mem_req_addr);
          end else begin
            checkOutput("req_addr", mem_req_addr, exp_req[0].addr);
            checkOutput("req_we", {31'b0, mem_req_we}, {31'b0, exp_req[0].we});
            checkOutput("req_wdata", mem_req_wdata, exp_req[0].wdata);
            if (mem_req_ready) void'(exp_req.pop_front());
          end
        end
        if (lsu_done && !done_prev) begin
          if (exp_res.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_done: got lsu_done 1, expected 0");
          end else begin
            r = exp_res.pop_front();
            for (int i = 0; i < 4; i++) checkOutput($sformatf("lsu_out[%0d]", i), lsu_out[i], r[i]);
          end
        end
      end
      done_prev = lsu_done;
    end
  end

  task automatic applyStimulus(input logic [3:0] mask, input logic rw, input data_t immv,
                               input lanes_t base, input lanes_t data, input int stall,
                               output int n);
    @(negedge clk);
    thread_enable = mask;
    DMemRW        = rw;
    imm           = immv;
    for (int i = 0; i < 4; i++) begin
      rs1[i] = base[i];
      rs2[i] = data[i];
    end
    warp_state  = WARP_REQUEST;
    warp_enable = 1'b1;
    DMemEN      = 1'b1;
    stall_cnt   = stall;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      warp_state  = WARP_EXECUTE;
      DMemEN      = 1'b0;
      warp_enable = 1'b0;
    end while (!lsu_done && n < 200);
    if (!lsu_done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got lsu_done 0 after %0d cycles, expected 1", n);
    end else begin
      @(negedge clk);
      checkOutput("done_held", {31'b0, lsu_done}, 32'd1);
      warp_state  = WARP_UPDATE;
      warp_enable = 1'b1;
      @(negedge clk);
      checkOutput("done_cleared", {31'b0, lsu_done}, 32'd0);
      warp_state  = WARP_EXECUTE;
      warp_enable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset         = 1'b0;
    warp_state    = WARP_IDLE;
    warp_enable   = 1'b0;
    thread_enable = '0;
    DMemEN        = 1'b0;
    DMemRW        = 1'b0;
    imm           = '0;
    for (int i = 0; i < 4; i++) begin
      rs1[i] = '0;
      rs2[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("rst_we", {31'b0, mem_req_we}, 32'd0);
    checkOutput("rst_addr", mem_req_addr, 32'd0);
    checkOutput("rst_wdata", mem_req_wdata, 32'd0);
    checkOutput("rst_done", {31'b0, lsu_done}, 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rst_lsu_out[%0d]", i), lsu_out[i], 32'd0);
    reset = 1'b1;

    $display("[TB] four loads, ascending lanes");
    pushReq(32'h14, 1'b0, 32'h11);
    pushReq(32'h18, 1'b0, 32'h22);
    pushReq(32'h1C, 1'b0, 32'h33);
    pushReq(32'h20, 1'b0, 32'h44);
    exp_res.push_back({32'h40, 32'h38, 32'h30, 32'h28});
    applyStimulus(4'b1111, 1'b0, 32'd4, {32'h1C, 32'h18, 32'h14, 32'h10},
                  {32'h44, 32'h33, 32'h22, 32'h11}, 0, cycles);
    checkOutput("load_latency", cycles, 32'd9);

    $display("[TB] masked stores");
    pushReq(32'h100, 1'b1, 32'hA);
    pushReq(32'h300, 1'b1, 32'hC);
    exp_res.push_back({32'h40, 32'h38, 32'h30, 32'h28});
    applyStimulus(4'b0101, 1'b1, 32'd0, {32'h400, 32'h300, 32'h200, 32'h100},
                  {32'hD, 32'hC, 32'hB, 32'hA}, 0, cycles);

    $display("[TB] empty mask");
    exp_res.push_back({32'h40, 32'h38, 32'h30, 32'h28});
    applyStimulus(4'b0000, 1'b0, 32'd0, {32'h4, 32'h3, 32'h2, 32'h1},
                  {32'h0, 32'h0, 32'h0, 32'h0}, 0, cycles);
    checkOutput("empty_latency", cycles, 32'd1);

    $display("[TB] ready stall, negative offset");
    pushReq(32'h4C, 1'b0, 32'h7);
    pushReq(32'h5C, 1'b0, 32'h8);
    exp_res.push_back({32'h40, 32'hB8, 32'h98, 32'h28});
    applyStimulus(4'b0110, 1'b0, 32'hFFFF_FFFC, {32'h0, 32'h60, 32'h50, 32'h0},
                  {32'h0, 32'h8, 32'h7, 32'h0}, 5, cycles);

    $display("[TB] address wrap");
    pushReq(32'h10, 1'b0, 32'h9);
    exp_res.push_back({32'h20, 32'hB8, 32'h98, 32'h28});
    applyStimulus(4'b1000, 1'b0, 32'h20, {32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0},
                  {32'h9, 32'h0, 32'h0, 32'h0}, 0, cycles);

    $display("[TB] same-address loads");
`ifdef LSU_COALESCE_EN
    pushReq(32'h40, 1'b0, 32'h1);
`else
    pushReq(32'h40, 1'b0, 32'h1);
    pushReq(32'h40, 1'b0, 32'h2);
    pushReq(32'h40, 1'b0, 32'h3);
    pushReq(32'h40, 1'b0, 32'h4);
`endif
    exp_res.push_back({32'h80, 32'h80, 32'h80, 32'h80});
    applyStimulus(4'b1111, 1'b0, 32'd4, {32'h3C, 32'h3C, 32'h3C, 32'h3C},
                  {32'h4, 32'h3, 32'h2, 32'h1}, 0, cycles);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    pushReq(32'h100, 1'b0, 32'h5);
    rsp_enable    = 1'b0;
    thread_enable = 4'b0001;
    DMemRW        = 1'b0;
    imm           = '0;
    rs1[0]        = 32'h100;
    rs2[0]        = 32'h5;
    warp_state    = WARP_REQUEST;
    warp_enable   = 1'b1;
    DMemEN        = 1'b1;
    @(negedge clk);
    warp_state  = WARP_EXECUTE;
    DMemEN      = 1'b0;
    warp_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_valid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("abort_done", {31'b0, lsu_done}, 32'd0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("abort_lsu_out[%0d]", i), lsu_out[i], 32'd0);
    @(negedge clk);
    reset      = 1'b1;
    rsp_enable = 1'b1;
    late_data  = 32'hDEAD;
    late_rsp   = 1'b1;
    @(negedge clk);
    late_rsp = 1'b0;
    checkOutput("late_rsp_lsu_out0", lsu_out[0], 32'd0);
    checkOutput("late_rsp_done", {31'b0, lsu_done}, 32'd0);
    @(negedge clk);
    checkOutput("late_rsp_valid", {31'b0, mem_req_valid}, 32'd0);

    checkOutput("req_queue_left", exp_req.size(), 32'd0);
    checkOutput("res_queue_left", exp_res.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
